uart_baud_rate: RTL and testbench

- Programmable baud-tick generator for the UART block.
- Divides the system clock by a run-time 32-bit divisor and emits a single-cycle `baud_tick` strobe.
- The strobe is consumed by the UART TX/RX as the 16x oversampling enable. Example: 20 MHz clk with divisor 130 gives 153.8 kHz ticks, i.e. about 9600 baud x16.
- Purely synchronous; one clock domain.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_rate.sv | 89 ++++++++
 tb/tb_uart_baud_rate.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART block.
//   DIV_W_DEFAULT           - default width of the baud divisor and its counter
//   baud_div_t              - divisor type at the default width
//   BAUD_DIV_9600_X16_20MHZ - 20 MHz clk, 9600 baud with 16x oversampling
package uart_pkg;

  localparam int DIV_W_DEFAULT = 32;

  typedef logic [DIV_W_DEFAULT-1:0] baud_div_t;

  localparam baud_div_t BAUD_DIV_9600_X16_20MHZ  = 32'd130;
  localparam baud_div_t BAUD_DIV_19200_X16_20MHZ = 32'd65;

endpackage : uart_pkg

// File: rtl/uart_baud_rate.sv
// uart_baud_rate: programmable baud-tick generator.
// Divides clk by a run-time divisor N and emits a one-cycle strobe every N
// clocks (the 16x oversampling enable for the UART TX/RX).
// Ports:
//   clk           - system clock, rising edge
//   rst           - synchronous active-low reset
//   baud_division - divisor N, sampled every cycle (0 and 1 both mean "every cycle")
//   baud_tick     - registered one-cycle strobe
// Build option: define UART_BAUD_RESYNC_EN to restart the period whenever
// baud_division changes (no tick on the change cycle).
module uart_baud_rate
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_division,
  output logic             baud_tick
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] counter_r;
  logic             tick_r;
  logic [DIV_W-1:0] limit_s;
  logic [DIV_W-1:0] counter_nxt_s;
  logic             tick_nxt_s;
  logic             restart_s;

`ifdef UART_BAUD_RESYNC_EN
  logic [DIV_W-1:0] prev_div_r;

  // Remember last cycle's divisor so a change can be detected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_div_r <= '0;
    end else begin
      prev_div_r <= baud_division;
    end
  end

  assign restart_s = (baud_division != prev_div_r);
`else
  assign restart_s = 1'b0;
`endif

  // Terminal count N-1, saturating at 0 so N=0 behaves like N=1.
  always_comb begin
    limit_s = '0;
    if (baud_division == '0) begin
      limit_s = '0;
    end else begin
      limit_s = baud_division - ONE;
    end
  end

  // Next counter/tick. The >= compare also catches a counter left above a
  // freshly lowered limit, so it wraps instead of running on; the increment
  // only happens while counter < limit <= 2^DIV_W-2, so it cannot overflow.
  always_comb begin
    counter_nxt_s = '0;
    tick_nxt_s    = 1'b0;
    if (restart_s) begin
      counter_nxt_s = '0;
      tick_nxt_s    = 1'b0;
    end else if (counter_r >= limit_s) begin
      counter_nxt_s = '0;
      tick_nxt_s    = 1'b1;
    end else begin
      counter_nxt_s = counter_r + ONE;
      tick_nxt_s    = 1'b0;
    end
  end

  // Counter and strobe registers; reset wins over a pending tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      counter_r <= '0;
      tick_r    <= 1'b0;
    end else begin
      counter_r <= counter_nxt_s;
      tick_r    <= tick_nxt_s;
    end
  end

  assign baud_tick = tick_r;

endmodule : uart_baud_rate

// File: tb/tb_uart_baud_rate.sv
// tb_uart_baud_rate: directed self-checking bench for uart_baud_rate
// (default build, immediate-compare behaviour).
module tb_uart_baud_rate;

  import uart_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] baud_division;
  logic        baud_tick;

  int total;
  int bad;

  uart_baud_rate #(.DIV_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_division (baud_division),
    .baud_tick     (baud_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report a mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until baud_tick is seen high (0 if the budget runs out).
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (baud_tick === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  // Hold reset for the given number of edges, returning how many ticks were seen.
  task automatic do_reset(input int cycles, output int highs);
    highs = 0;
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (baud_tick !== 1'b0) highs++;
    end
  endtask

  initial begin
    int n;
    int highs;
    int ticks;
    int first;
    int last;
    int bad_gap;
    int dbl;
    logic prev;

    total = 0;
    bad   = 0;
    rst   = 1'b0;
    baud_division = BAUD_DIV_9600_X16_20MHZ;

    // 1: reset quiet, first tick at 130, 153 ticks in 20000 cycles, 1 cycle wide
    do_reset(10, highs);
    chk("t1_reset_quiet", highs, 32'd0);
    chk("t1_reset_value", {31'd0, baud_tick}, 32'd0);
    rst = 1'b1;
    ticks = 0; first = 0; last = 0; bad_gap = 0; dbl = 0; prev = 1'b0;
    for (int c = 1; c <= 20000; c++) begin
      step();
      if (baud_tick === 1'b1) begin
        ticks++;
        if (first == 0) first = c;
        else if (c - last != 130) bad_gap++;
        last = c;
        if (prev === 1'b1) dbl++;
      end
      prev = baud_tick;
    end
    chk("t1_first_latency", first, 32'd130);
    chk("t1_tick_count", ticks, 32'd153);
    chk("t1_period", bad_gap, 32'd0);
    chk("t1_width", dbl, 32'd0);

    // 2: reset for one cycle when counter=129 suppresses the due tick
    wait_tick(200, n);
    chk("t2_align", (n > 0) ? 32'd1 : 32'd0, 32'd1);
    repeat (129) step();
    chk("t2_pre", {31'd0, baud_tick}, 32'd0);
    rst = 1'b0;
    step();
    chk("t2_suppressed", {31'd0, baud_tick}, 32'd0);
    rst = 1'b1;
    wait_tick(300, n);
    chk("t2_restart_latency", n, 32'd130);

    // 3: N=0 then N=1 give a continuous strobe
    for (int d = 0; d < 2; d++) begin
      baud_division = d;
      do_reset(3, highs);
      rst = 1'b1;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (baud_tick === 1'b1) highs++;
      end
      chk((d == 0) ? "t3_n0_continuous" : "t3_n1_continuous", highs, 32'd20);
    end

    // 4: drop N from 130 to 50 at counter=100 -> immediate tick, then every 50
    baud_division = 32'd130;
    do_reset(2, highs);
    rst = 1'b1;
    repeat (100) step();
    chk("t4_no_early_tick", {31'd0, baud_tick}, 32'd0);
    baud_division = 32'd50;
    step();
    chk("t4_immediate_tick", {31'd0, baud_tick}, 32'd1);
    wait_tick(200, n);
    chk("t4_gap1", n, 32'd50);
    wait_tick(200, n);
    chk("t4_gap2", n, 32'd50);

    // 5: N=4 for three periods, then N=2 at a tick boundary
    baud_division = 32'd4;
    do_reset(2, highs);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(20, n);
      chk("t5_gap4", n, 32'd4);
    end
    baud_division = 32'd2;
    for (int k = 0; k < 3; k++) begin
      wait_tick(20, n);
      chk("t5_gap2", n, 32'd2);
    end

    // 6: long reset never ticks
    baud_division = BAUD_DIV_9600_X16_20MHZ;
    do_reset(1000, highs);
    chk("t6_long_reset", highs, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_baud_rate
